// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the ALU and its iterative MUL AB / DIV AB unit.
// Holds the md_op select codes, the MUL/DIV FSM state encoding and the ALU opcodes.
package alu_muldiv_pkg;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_ADDC = 4'h1;
  localparam logic [3:0] ALU_SUBB = 4'h2;
  localparam logic [3:0] ALU_ANL  = 4'h3;
  localparam logic [3:0] ALU_ORL  = 4'h4;
  localparam logic [3:0] ALU_XRL  = 4'h5;
  localparam logic [3:0] ALU_MUL  = 4'h6;
  localparam logic [3:0] ALU_DIV  = 4'h7;

  localparam int unsigned MD_ITERS = 8;
  localparam logic [2:0]  ITER_LAST = 3'(MD_ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } md_state_e;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative 8x8 unsigned multiply / 8/8 restoring divide, one bit per clock.
// MUL and DIV share one 3-bit iteration counter and one 16-bit working register.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter logic [7:0] DIV0_QUOT = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       md_op,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic       ov_out,
  output logic       cy_out
);

  md_state_e   state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [15:0] work_reg, work_next;
  logic [7:0]  bop_reg, bop_next;
  logic        op_reg, op_next;
  logic        done_reg, done_next;
  logic [7:0]  a_out_reg, a_out_next;
  logic [7:0]  b_out_reg, b_out_next;
  logic        ov_reg, ov_next;
  logic        cy_reg, cy_next;

  // Single iteration of each datapath, evaluated from the working register.
  logic [8:0]  mul_sum;
  logic [15:0] mul_step;
  logic [8:0]  rem9;
  logic        div_ge;
  logic [7:0]  rem_diff;
  logic [15:0] div_step;
  logic [15:0] step;

  always_comb begin
    mul_sum  = {1'b0, work_reg[15:8]} + (work_reg[0] ? {1'b0, bop_reg} : 9'd0);
    mul_step = {mul_sum, work_reg[7:1]};
    // Remainder is always below the divisor, so the shifted partial fits 9 bits.
    rem9     = work_reg[15:7];
    div_ge   = (rem9 >= {1'b0, bop_reg});
    rem_diff = rem9[7:0] - bop_reg;
    div_step = div_ge ? {rem_diff, work_reg[6:0], 1'b1}
                      : {rem9[7:0], work_reg[6:0], 1'b0};
    step     = (op_reg == MD_DIV) ? div_step : mul_step;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    work_next  = work_reg;
    bop_next   = bop_reg;
    op_next    = op_reg;
    done_next  = (state_reg == ST_FIN);
    a_out_next = a_out_reg;
    b_out_next = b_out_reg;
    ov_next    = ov_reg;
    cy_next    = cy_reg;

    case (state_reg)
      ST_IDLE: begin
        // done_reg still high means the previous result is being presented.
        if (start && !done_reg) begin
          op_next   = md_op;
          bop_next  = b_in;
          cnt_next  = 3'd0;
          work_next = {8'h00, a_in};
          if (md_op == MD_DIV && b_in == 8'h00) begin
            state_next = ST_FIN;
            a_out_next = DIV0_QUOT;
            b_out_next = a_in;
            ov_next    = 1'b1;
            cy_next    = 1'b0;
          end else begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        work_next = step;
        cnt_next  = cnt_reg + 3'd1;
        if (cnt_reg == ITER_LAST) begin
          state_next = ST_FIN;
          a_out_next = step[7:0];
          b_out_next = step[15:8];
          ov_next    = (op_reg == MD_MUL) ? (|step[15:8]) : 1'b0;
          cy_next    = 1'b0;
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 3'd0;
      work_reg  <= 16'h0000;
      bop_reg   <= 8'h00;
      op_reg    <= MD_MUL;
      done_reg  <= 1'b0;
      a_out_reg <= 8'h00;
      b_out_reg <= 8'h00;
      ov_reg    <= 1'b0;
      cy_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      work_reg  <= work_next;
      bop_reg   <= bop_next;
      op_reg    <= op_next;
      done_reg  <= done_next;
      a_out_reg <= a_out_next;
      b_out_reg <= b_out_next;
      ov_reg    <= ov_next;
      cy_reg    <= cy_next;
    end
  end

  assign busy   = (state_reg != ST_IDLE) || done_reg;
  assign done   = done_reg;
  assign a_out  = a_out_reg;
  assign b_out  = b_out_reg;
  assign ov_out = ov_reg;
  assign cy_out = cy_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: driver pushes arithmetic expectations,
// a negedge monitor pops and checks them whenever done is presented.
module tb_alu_muldiv;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       md_op = 1'b0;
  logic [7:0] a_in  = 8'h00;
  logic [7:0] b_in  = 8'h00;
  logic       busy, done, ov_out, cy_out;
  logic [7:0] a_out, b_out;

  alu_muldiv #(.DIV0_QUOT(8'hFF)) dut (
    .clock(clock), .reset(reset), .start(start), .md_op(md_op),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .a_out(a_out), .b_out(b_out), .ov_out(ov_out), .cy_out(cy_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       op;
    logic [7:0] a_src;
    logic [7:0] b_src;
    logic [7:0] a;
    logic [7:0] b;
    logic       ov;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  logic [7:0] last_a = 8'h00;
  logic [7:0] last_b = 8'h00;
  logic       last_ov = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the MUL AB / DIV AB definitions.
  function automatic exp_t model(input logic op, input logic [7:0] a, input logic [7:0] b,
                                 input int acc);
    exp_t e;
    int   p;
    e.op = op; e.a_src = a; e.b_src = b;
    if (op == 1'b0) begin
      p = int'(a) * int'(b);
      e.a = p[7:0]; e.b = p[15:8]; e.ov = (p > 255); e.cyc = acc + 9;
    end else if (b == 8'h00) begin
      e.a = 8'hFF; e.b = a; e.ov = 1'b1; e.cyc = acc + 1;
    end else begin
      e.a = a / b; e.b = a % b; e.ov = 1'b0; e.cyc = acc + 9;
    end
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      last_a = 8'h00; last_b = 8'h00; last_ov = 1'b0;
    end else if (done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", {7'd0, done}, 16'd0);
      end else begin
        e = sb_q.pop_front();
        $display("[TB] %s a=%h b=%h -> a_out=%h b_out=%h ov=%b cy=%b at cycle %0d (exp %h %h %b @%0d)",
                 e.op ? "DIV" : "MUL", e.a_src, e.b_src, a_out, b_out, ov_out, cy_out, cyc,
                 e.a, e.b, e.ov, e.cyc);
        chk("result", {a_out, b_out}, {e.a, e.b});
        chk("ov", {15'd0, ov_out}, {15'd0, e.ov});
        chk("cy", {15'd0, cy_out}, 16'd0);
        chk("latency", 16'(cyc), 16'(e.cyc));
        last_a = e.a; last_b = e.b; last_ov = e.ov;
      end
    end else begin
      if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
        e = sb_q.pop_front();
        chk("missing_done", 16'(cyc), 16'(e.cyc));
      end
      if (!busy) chk("hold", {a_out, b_out}, {last_a, last_b});
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (busy) chk("idle_timeout", {15'd0, busy}, 16'd0);
  endtask

  // Leaves the bench at the negedge right after the accept edge.
  task automatic issue(input logic op, input logic [7:0] a, input logic [7:0] b);
    wait_idle();
    md_op = op; a_in = a; b_in = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    sb_q.push_back(model(op, a, b, cyc));
    md_op = 1'($urandom); a_in = 8'($urandom); b_in = 8'($urandom);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clock);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_ab", {a_out, b_out}, 16'h0000);
    chk("rst_flags", {14'd0, ov_out, cy_out}, 16'd0);
    reset = 1'b0;

    issue(1'b0, 8'h50, 8'hA0);
    issue(1'b0, 8'h0C, 8'h0A);
    issue(1'b1, 8'hFB, 8'h12);
    issue(1'b1, 8'h37, 8'h00);
    issue(1'b0, 8'h00, 8'hC3);
    issue(1'b0, 8'hFF, 8'hFF);
    issue(1'b1, 8'h05, 8'hFF);

    // Second start while running must be dropped.
    issue(1'b0, 8'h11, 8'h22);
    repeat (3) @(negedge clock);
    md_op = 1'b1; a_in = 8'h99; b_in = 8'h03; start = 1'b1;
    @(negedge clock);
    start = 1'b0;

    // Start presented during the done cycle must be dropped too.
    issue(1'b1, 8'hC8, 8'h07);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("done_seen", {15'd0, done}, 16'd1);
    md_op = 1'b0; a_in = 8'h0F; b_in = 8'h0F; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_in_done_ignored", {15'd0, busy}, 16'd0);

    // Reset mid-RUN aborts without a done pulse.
    issue(1'b0, 8'h7E, 8'h3D);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clock);
    chk("abort_busy", {14'd0, busy, done}, 16'd0);
    chk("abort_ab", {a_out, b_out}, 16'h0000);
    chk("abort_flags", {14'd0, ov_out, cy_out}, 16'd0);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    issue(1'b0, 8'h02, 8'h03);

    for (int i = 0; i < 40; i++) begin
      logic       op;
      logic [7:0] a, b;
      op = 1'($urandom);
      a  = 8'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      issue(op, a, b);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    wait_idle();
    repeat (3) @(negedge clock);
    chk("scoreboard_empty", 16'(sb_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
